// File: rtl/regfile_bist.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_bist : RegFile self test using a two-phase complementary   |
// |                pattern; reports pass, mismatch count, first fail.  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module regfile_bist #(
    parameter int          NREG     = 32,
    parameter int          READ_LAT = 1,
    parameter logic [31:0] SEED     = 32'hA5A5_0000,
    parameter bit          X0_ZERO  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        en,
    output logic        readEn,
    output logic        writeEn,
    output logic [4:0]  rd,
    output logic [31:0] dataIn,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] readOut1,
    input  logic [31:0] readOut2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [4:0]  fail_addr,
    output logic        fail_phase
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] C_LAST  = 5'(NREG - 1);
    localparam logic [4:0] C_DLAST = 5'(READ_LAT - 1);

    state_t     r_state, w_state_nxt;
    logic [4:0] r_cnt, w_cnt_nxt;
    logic       r_phase, w_phase_nxt;
    logic       w_restart;

    function automatic logic [31:0] pat(input logic [4:0] a, input logic p);
        logic [31:0] s;
        s = SEED + {27'd0, a};
        return p ? ~s : s;
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] a, input logic p);
        if (X0_ZERO && (a == 5'd0))
            return 32'd0;
        return pat(a, p);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_restart   = 1'b0;
        en          = 1'b0;
        busy        = 1'b0;
        readEn      = 1'b0;
        writeEn     = 1'b0;
        rd          = 5'd0;
        dataIn      = 32'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = S_WRITE;
                    w_cnt_nxt   = 5'd0;
                    w_phase_nxt = 1'b0;
                end
            end
            S_WRITE: begin
                busy    = 1'b1;
                en      = 1'b1;
                writeEn = 1'b1;
                rd      = r_cnt;
                dataIn  = pat(r_cnt, r_phase);
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_READ;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_READ: begin
                busy   = 1'b1;
                en     = 1'b1;
                readEn = 1'b1;
                rs1    = r_cnt;
                rs2    = C_LAST - r_cnt;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                en   = 1'b1;
                if (r_cnt == C_DLAST) begin
                    w_cnt_nxt = 5'd0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read tags travel alongside the RegFile read latency so each compare
    // knows which address/phase the returning data belongs to.
    logic       r_tv  [READ_LAT];
    logic [4:0] r_ta1 [READ_LAT];
    logic [4:0] r_ta2 [READ_LAT];
    logic       r_tp  [READ_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_tv[i]  <= 1'b0;
                r_ta1[i] <= 5'd0;
                r_ta2[i] <= 5'd0;
                r_tp[i]  <= 1'b0;
            end
        end else begin
            r_tv[0]  <= readEn;
            r_ta1[0] <= rs1;
            r_ta2[0] <= rs2;
            r_tp[0]  <= r_phase;
            for (int i = 1; i < READ_LAT; i++) begin
                r_tv[i]  <= r_tv[i-1];
                r_ta1[i] <= r_ta1[i-1];
                r_ta2[i] <= r_ta2[i-1];
                r_tp[i]  <= r_tp[i-1];
            end
        end
    end

    logic       w_bad1, w_bad2;
    logic [8:0] w_sum;
    logic       r_first;

    assign w_bad1 = r_tv[READ_LAT-1] &&
                    (readOut1 != exp_val(r_ta1[READ_LAT-1], r_tp[READ_LAT-1]));
    assign w_bad2 = r_tv[READ_LAT-1] &&
                    (readOut2 != exp_val(r_ta2[READ_LAT-1], r_tp[READ_LAT-1]));
    assign w_sum  = {1'b0, fail_count} + {8'd0, w_bad1} + {8'd0, w_bad2};

    // done/pass lag the DONE state by one clock so pass sees the final count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_count <= 8'd0;
            fail_addr  <= 5'd0;
            fail_phase <= 1'b0;
            r_first    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (w_restart) begin
            fail_count <= 8'd0;
            fail_addr  <= 5'd0;
            fail_phase <= 1'b0;
            r_first    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            if (w_bad1 || w_bad2) begin
                fail_count <= w_sum[8] ? 8'hFF : w_sum[7:0];
                if (!r_first) begin
                    r_first    <= 1'b1;
                    fail_addr  <= w_bad1 ? r_ta1[READ_LAT-1] : r_ta2[READ_LAT-1];
                    fail_phase <= r_tp[READ_LAT-1];
                end
            end
            done <= (r_state == S_DONE);
            pass <= (r_state == S_DONE) && (fail_count == 8'd0);
        end
    end

endmodule
`default_nettype wire
